// File: rtl/pipe_stage_buf.sv
// Valid/ready pipeline stage with a 2-entry skid buffer and split control/data fields.
// Optional build macro PIPE_STAGE_CLR_DATA_EN: bubbles carry zero data and flush zeroes data.
module pipe_stage_buf #(
   parameter int unsigned CTRL_W = 9,
   parameter int unsigned DATA_W = 95
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [CTRL_W-1:0] in_ctrl,
   input  logic [DATA_W-1:0] in_data,
   input  logic              bubble,
   input  logic              flush,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [CTRL_W-1:0] out_ctrl,
   output logic [DATA_W-1:0] out_data,
   output logic [1:0]        occupancy
);

   typedef enum logic [1:0] {StEmpty, StOne, StTwo} state_e;

   state_e            state_q, state_d;
   logic [CTRL_W-1:0] main_ctrl_q, main_ctrl_d;
   logic [CTRL_W-1:0] skid_ctrl_q, skid_ctrl_d;
   logic [DATA_W-1:0] main_data_q, main_data_d;
   logic [DATA_W-1:0] skid_data_q, skid_data_d;

   logic              main_valid;
   logic              skid_valid;
   logic              push_up;
   logic              push_bub;
   logic              push;
   logic              pop;
   logic [CTRL_W-1:0] push_ctrl;
   logic [DATA_W-1:0] push_data;

   assign main_valid = (state_q != StEmpty);
   assign skid_valid = (state_q == StTwo);

   // Registered-only ready: never sees out_ready.
   assign in_ready = ~skid_valid & ~flush & ~bubble;

   assign push_up  = in_valid & in_ready;
   assign push_bub = bubble & ~skid_valid & ~flush;
   assign push     = push_up | push_bub;
   assign pop      = main_valid & out_ready;

   assign push_ctrl = push_bub ? '0 : in_ctrl;
`ifdef PIPE_STAGE_CLR_DATA_EN
   assign push_data = push_bub ? '0 : in_data;
`else
   // Bubbles keep in_data so register indices stay visible to hazard logic.
   assign push_data = in_data;
`endif

   always_comb begin
      state_d     = state_q;
      main_ctrl_d = main_ctrl_q;
      main_data_d = main_data_q;
      skid_ctrl_d = skid_ctrl_q;
      skid_data_d = skid_data_q;

      if (flush) begin
         state_d     = StEmpty;
         main_ctrl_d = '0;
         skid_ctrl_d = '0;
`ifdef PIPE_STAGE_CLR_DATA_EN
         main_data_d = '0;
         skid_data_d = '0;
`endif
      end else begin
         unique case (state_q)
            StEmpty: begin
               if (push) begin
                  state_d     = StOne;
                  main_ctrl_d = push_ctrl;
                  main_data_d = push_data;
               end
            end
            StOne: begin
               if (push && pop) begin
                  main_ctrl_d = push_ctrl;
                  main_data_d = push_data;
               end else if (push) begin
                  state_d     = StTwo;
                  skid_ctrl_d = push_ctrl;
                  skid_data_d = push_data;
               end else if (pop) begin
                  state_d = StEmpty;
               end
            end
            StTwo: begin
               if (pop) begin
                  state_d     = StOne;
                  main_ctrl_d = skid_ctrl_q;
                  main_data_d = skid_data_q;
               end
            end
            default: state_d = StEmpty;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q     <= StEmpty;
         main_ctrl_q <= '0;
         main_data_q <= '0;
         skid_ctrl_q <= '0;
         skid_data_q <= '0;
      end else begin
         state_q     <= state_d;
         main_ctrl_q <= main_ctrl_d;
         main_data_q <= main_data_d;
         skid_ctrl_q <= skid_ctrl_d;
         skid_data_q <= skid_data_d;
      end
   end

   assign out_valid = main_valid;
   assign out_ctrl  = main_valid ? main_ctrl_q : '0;
   assign out_data  = main_data_q;

   always_comb begin
      occupancy = 2'd0;
      unique case (state_q)
         StEmpty: occupancy = 2'd0;
         StOne:   occupancy = 2'd1;
         StTwo:   occupancy = 2'd2;
         default: occupancy = 2'd0;
      endcase
   end

endmodule

// File: tb/tb_pipe_stage_buf.sv
// Directed self-checking bench for pipe_stage_buf (both data-clear build options).
module tb_pipe_stage_buf;

   localparam int unsigned CTRL_W = 9;
   localparam int unsigned DATA_W = 95;

   logic              clk = 1'b0;
   logic              rst;
   logic              in_valid;
   logic              in_ready;
   logic [CTRL_W-1:0] in_ctrl;
   logic [DATA_W-1:0] in_data;
   logic              bubble;
   logic              flush;
   logic              out_valid;
   logic              out_ready;
   logic [CTRL_W-1:0] out_ctrl;
   logic [DATA_W-1:0] out_data;
   logic [1:0]        occupancy;

   int checks = 0;
   int errors = 0;

   pipe_stage_buf #(.CTRL_W(CTRL_W), .DATA_W(DATA_W)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_ctrl   (in_ctrl),
      .in_data   (in_data),
      .bubble    (bubble),
      .flush     (flush),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_ctrl  (out_ctrl),
      .out_data  (out_data),
      .occupancy (occupancy)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic v, input logic [CTRL_W-1:0] c, input logic [DATA_W-1:0] d);
      in_valid = v;
      in_ctrl  = c;
      in_data  = d;
   endtask

   task automatic chk_out(input string tag, input logic v, input logic [CTRL_W-1:0] c,
                          input logic [DATA_W-1:0] d, input logic [1:0] occ);
      chk({tag, ".valid"}, 128'(out_valid), 128'(v));
      chk({tag, ".ctrl"}, 128'(out_ctrl), 128'(c));
      chk({tag, ".data"}, 128'(out_data), 128'(d));
      chk({tag, ".occ"}, 128'(occupancy), 128'(occ));
   endtask

   logic [DATA_W-1:0] exp_bub_data;
   logic [DATA_W-1:0] exp_flush_data;

   initial begin
      rst = 1'b0;
      bubble = 1'b0;
      flush = 1'b0;
      out_ready = 1'b0;
      drive(1'b0, '0, '0);
      tick();
      tick();
      chk_out("reset", 1'b0, '0, '0, 2'd0);
      rst = 1'b1;
      #1;
      chk("reset.in_ready", 128'(in_ready), 128'(1'b1));

      // Streaming at full rate.
      out_ready = 1'b1;
      for (int i = 1; i <= 8; i++) begin
         drive(1'b1, 9'h1A5, DATA_W'(i));
         tick();
         chk_out($sformatf("stream%0d", i), 1'b1, 9'h1A5, DATA_W'(i), 2'd1);
      end
      drive(1'b0, '0, '0);
      tick();
      chk_out("stream_drain", 1'b0, '0, DATA_W'(8), 2'd0);

      // Backpressure: A, B absorbed, C held off.
      out_ready = 1'b0;
      drive(1'b1, 9'h011, DATA_W'('hA));
      tick();
      chk_out("bp_a", 1'b1, 9'h011, DATA_W'('hA), 2'd1);
      drive(1'b1, 9'h012, DATA_W'('hB));
      #1;
      chk("bp_b.in_ready", 128'(in_ready), 128'(1'b1));
      tick();
      chk_out("bp_b", 1'b1, 9'h011, DATA_W'('hA), 2'd2);
      drive(1'b1, 9'h013, DATA_W'('hC));
      #1;
      chk("bp_c.in_ready", 128'(in_ready), 128'(1'b0));
      tick();
      chk_out("bp_hold", 1'b1, 9'h011, DATA_W'('hA), 2'd2);
      out_ready = 1'b1;
      tick();
      chk_out("bp_out_b", 1'b1, 9'h012, DATA_W'('hB), 2'd1);
      tick();
      chk_out("bp_out_c", 1'b1, 9'h013, DATA_W'('hC), 2'd1);
      drive(1'b0, '0, '0);
      tick();
      chk_out("bp_drain", 1'b0, '0, DATA_W'('hC), 2'd0);

`ifdef PIPE_STAGE_CLR_DATA_EN
      exp_bub_data = '0;
`else
      exp_bub_data = DATA_W'('h00ABCDEF);
`endif
      // Bubble injected from ONE.
      out_ready = 1'b0;
      drive(1'b1, 9'h0FF, DATA_W'('h123));
      tick();
      drive(1'b0, '0, DATA_W'('h00ABCDEF));
      bubble = 1'b1;
      #1;
      chk("bub.in_ready", 128'(in_ready), 128'(1'b0));
      tick();
      bubble = 1'b0;
      chk_out("bub_two", 1'b1, 9'h0FF, DATA_W'('h123), 2'd2);
      out_ready = 1'b1;
      tick();
      chk_out("bub_beat", 1'b1, '0, exp_bub_data, 2'd1);
      tick();
      chk("bub_drain.occ", 128'(occupancy), 128'(2'd0));

      // Bubble held in TWO waits for the skid slot to free.
      out_ready = 1'b0;
      drive(1'b1, 9'h101, DATA_W'('hE));
      tick();
      drive(1'b1, 9'h102, DATA_W'('hF));
      tick();
      drive(1'b0, '0, DATA_W'('h55));
      bubble = 1'b1;
      tick();
      chk_out("bub2_hold", 1'b1, 9'h101, DATA_W'('hE), 2'd2);
      out_ready = 1'b1;
      tick();
      chk_out("bub2_f", 1'b1, 9'h102, DATA_W'('hF), 2'd1);
      tick();
`ifdef PIPE_STAGE_CLR_DATA_EN
      chk_out("bub2_beat", 1'b1, '0, '0, 2'd1);
`else
      chk_out("bub2_beat", 1'b1, '0, DATA_W'('h55), 2'd1);
`endif
      bubble = 1'b0;
      tick();
      chk("bub2_drain.occ", 128'(occupancy), 128'(2'd0));

      // Flush from TWO drops everything, including the input beat.
      out_ready = 1'b0;
      drive(1'b1, 9'h0A1, DATA_W'('h71));
      tick();
      drive(1'b1, 9'h0A2, DATA_W'('h72));
      tick();
      drive(1'b1, 9'h1FF, DATA_W'('h99));
      flush = 1'b1;
      #1;
      chk("flush.in_ready", 128'(in_ready), 128'(1'b0));
      tick();
      flush = 1'b0;
      drive(1'b0, '0, '0);
`ifdef PIPE_STAGE_CLR_DATA_EN
      exp_flush_data = '0;
`else
      exp_flush_data = DATA_W'('h71);
`endif
      chk_out("flush", 1'b0, '0, exp_flush_data, 2'd0);
      out_ready = 1'b1;
      tick();
      chk("flush_after.valid", 128'(out_valid), 128'(1'b0));

      // Flush beats bubble in ONE.
      out_ready = 1'b0;
      drive(1'b1, 9'h0C3, DATA_W'('h33));
      tick();
      drive(1'b0, '0, '0);
      flush = 1'b1;
      bubble = 1'b1;
      tick();
      flush = 1'b0;
      bubble = 1'b0;
      chk("fb.occ", 128'(occupancy), 128'(2'd0));
      chk("fb.valid", 128'(out_valid), 128'(1'b0));
      tick();
      chk("fb_after.valid", 128'(out_valid), 128'(1'b0));

      // Asynchronous reset with two beats held.
      drive(1'b1, 9'h0D1, DATA_W'('h41));
      tick();
      drive(1'b1, 9'h0D2, DATA_W'('h42));
      tick();
      drive(1'b0, '0, '0);
      chk("pre_rst.occ", 128'(occupancy), 128'(2'd2));
      #2;
      rst = 1'b0;
      #1;
      chk_out("async_rst", 1'b0, '0, '0, 2'd0);
      tick();
      rst = 1'b1;
      #1;
      chk("rst_rel.in_ready", 128'(in_ready), 128'(1'b1));
      tick();
      chk("rst_rel.occ", 128'(occupancy), 128'(2'd0));

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/pipe_stage_buf.md
# pipe_stage_buf

Parametrised pipeline stage register for the pipelined CPU. It replaces fixed-width inter-stage latches (ID/EX and its siblings) with a valid/ready stage that has a 2-entry skid buffer. The buffer sustains full throughput while keeping `in_ready` free of any path from `out_ready`. The block splits each beat into a control field and a data field, so a hazard bubble or a flush can zero the control field while the data field stays intact. It sits between any two pipeline stages; one instance per boundary.

## Interface
Parameters:
- `CTRL_W`, 9: control field width (WB+M+EX bits).
- `DATA_W`, 95: data field width (regs, imm, bus values).

Ports:
- `clk` in 1: single clock; all state updates on rising edge.
- `rst` in 1: reset, asynchronous, active-low (asserted at 0).
- `in_valid` in 1: upstream beat present.
- `in_ready` out 1: stage accepts a beat this cycle.
- `in_ctrl` in CTRL_W: upstream control field.
- `in_data` in DATA_W: upstream data field.
- `bubble` in 1: inject a zero-control beat in place of the upstream beat (load-use stall).
- `flush` in 1: discard all held beats (branch/exception).
- `out_valid` out 1: a beat is presented downstream.
- `out_ready` in 1: downstream accepts the presented beat.
- `out_ctrl` out CTRL_W: presented control field.
- `out_data` out DATA_W: presented data field.
- `occupancy` out 2: number of held beats, 0..2.

## Operation
- Storage: main slot (drives outputs) and skid slot; each slot has a valid flop, a control register and a data register.
- States: EMPTY (no valid slot), ONE (main valid), TWO (main and skid valid). `occupancy` is 0/1/2 respectively.
- `in_ready = ~skid_valid & ~flush & ~bubble`. It depends only on flops and the two hazard inputs, never on `out_ready`.
- Push is `in_valid & in_ready`. Pop is `out_valid & out_ready`.
- EMPTY + push → ONE; main loads the input.
- ONE + push + pop → ONE; main loads the input.
- ONE + push + no pop → TWO; skid loads the input.
- ONE + pop + no push → EMPTY.
- TWO + pop → ONE; main loads the skid slot.
- TWO + no pop → TWO; hold.
- Bubble is accepted only when `skid_valid=0` and `flush=0`. It is handled exactly as a push whose control field is all zeros; its data field is set by the Configuration section. If `skid_valid=1`, bubble has no effect that cycle and the caller holds it asserted.
- A bubble beat is valid (`out_valid=1`) and passes through the pipeline like any beat; its control field is all zeros.
- Flush has highest priority. Next edge: both valid flops and both control registers are cleared. Data registers follow the Configuration section. The upstream beat in that cycle is dropped, since `in_ready` is 0. Any pop in that cycle still completes downstream, as `out_valid` was 1.
- `out_ctrl` is all zeros whenever `out_valid=0`.
- No combinational path from `in_*` to `out_*`.

## Timing
- Reset (`rst=0`, asynchronous): state EMPTY. `out_valid=0`, `out_ctrl=0`, `out_data=0`, `occupancy=0`, skid slot cleared. `in_ready` reads 1 once `flush` and `bubble` are low.
- Latency: a beat pushed at edge N is on `out_*` after edge N (1 cycle) if main was free or popping. Otherwise it appears one cycle after the next pop.
- Throughput: 1 beat/cycle with `out_ready` held high.
- With `out_ready` low, the stage absorbs exactly 2 beats, then `in_ready` falls on the cycle after the second push.
- Reset deassertion is synchronised outside this block. Reset mid-operation discards all beats immediately, without waiting for a clock edge.

## Configuration
- `PIPE_STAGE_CLR_DATA_EN` defined: bubble beats carry `DATA_W` zeros. Flush also zeroes both data registers.
- Not defined: bubble beats carry `in_data` of that cycle. Flush leaves data registers unchanged. This keeps register indices visible to downstream hazard detection. It is the default build.
- The control-field and valid behaviour is identical in both builds.

## Test plan
- Reset: hold `rst=0` mid-stream with 2 beats held → `out_valid=0`, `occupancy=0`, `out_ctrl=0` before the next clock edge. After release, `in_ready=1`.
- Streaming: `out_ready=1`, push `ctrl=0x1A5`, data 1..8 on consecutive cycles → same 8 beats out, each 1 cycle later, `occupancy` stays 1.
- Backpressure: `out_ready=0`, push beats A, B, C on three consecutive cycles → A and B accepted, `in_ready=0` on the third cycle, C not taken. Then `out_ready=1` → A, B, then C appear in order, with no loss or duplication.
- Bubble: ONE state, `in_data=0x00ABCDEF`, `bubble=1` for 1 cycle → a beat with `out_ctrl=0` and `out_valid=1`. Default build: `out_data=0x00ABCDEF`. `PIPE_STAGE_CLR_DATA_EN` build: `out_data=0`. Bubble asserted in TWO → no injection until a pop frees the skid slot.
- Flush: TWO state, `flush=1` with `in_valid=1` → next cycle `occupancy=0`, `out_valid=0`, `out_ctrl=0`, and the input beat is absent from all later output.
- Simultaneous: `flush` and `bubble` both high in ONE → flush wins, `occupancy=0`, no bubble emitted.
